// File: rtl/push_arbiter.sv
// Round-robin arbiter feeding a FIFO push port: locks onto one requester, forwards one word, then re-arbitrates.
// Optional burst mode (define PUSH_ARB_BURST_EN) lets one requester keep priority for up to BURST_LEN transfers.
module push_arbiter #(
    parameter int DATA_WIDTH = 10,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_grant_o,
    output logic                          push_valid_o,
    output logic [DATA_WIDTH-1:0]         push_data_o,
    input  logic                          push_grant_i,
    output logic [$clog2(NUM_REQ)-1:0]    owner_o,
    output logic                          busy_o
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_ptr;
    logic [CW-1:0]   r_burst_cnt;

    logic [DATA_WIDTH-1:0] w_words [NUM_REQ];
    logic [OW-1:0]         w_sel;
    logic [OW-1:0]         w_owner_next;
    logic                  w_locked;
    logic                  w_owner_valid;
    logic                  w_xfer;
    logic [NUM_REQ-1:0]    w_grant;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_words[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        int idx;
        idx   = 0;
        w_sel = r_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(r_ptr) + i) % NUM_REQ;
            if (req_valid_i[idx]) begin
                w_sel = OW'(idx);
            end
        end
    end

    assign w_owner_next  = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + OW'(1);

    // Handshake: the word is offered while LOCKED; it moves only in a cycle where
    // push_grant_i and the owner's req_valid_i are both high, and req_grant_o marks that cycle.
    assign w_locked      = (r_state == S_LOCKED) && !reset;
    assign w_owner_valid = req_valid_i[r_owner];
    assign w_xfer        = w_locked && push_grant_i && w_owner_valid;

    always_comb begin
        w_grant = '0;
        if (w_xfer) begin
            w_grant[r_owner] = 1'b1;
        end
    end

    assign req_grant_o  = w_grant;
    assign push_valid_o = w_locked;
    assign busy_o       = w_locked;
    assign push_data_o  = w_locked ? w_words[r_owner] : '0;
    assign owner_o      = r_owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req_valid_i) begin
                        r_owner     <= w_sel;
                        r_state     <= S_LOCKED;
                        r_burst_cnt <= (w_sel == r_ptr) ? r_burst_cnt : '0;
                    end
                end
                S_LOCKED: begin
                    if (!w_owner_valid) begin
                        r_state <= S_IDLE;
                    end else if (push_grant_i) begin
                        r_state <= S_IDLE;
`ifdef PUSH_ARB_BURST_EN
                        if (int'(r_burst_cnt) + 1 < BURST_LEN) begin
                            r_ptr       <= r_owner;
                            r_burst_cnt <= r_burst_cnt + CW'(1);
                        end else begin
                            r_ptr       <= w_owner_next;
                            r_burst_cnt <= '0;
                        end
`else
                        r_ptr       <= w_owner_next;
                        r_burst_cnt <= '0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_push_arbiter.sv
// Directed bench for push_arbiter: stimulus pushes expected {grant, data} pairs,
// a negedge monitor pops and compares whenever a grant appears.
module tb_push_arbiter;

    localparam int DW = 10;
    localparam int NR = 4;
    localparam int BL = 4;

    logic          clk;
    logic          reset;
    logic [NR-1:0] req_valid_i;
    logic [NR*DW-1:0] req_data_i;
    logic [NR-1:0] req_grant_o;
    logic          push_valid_o;
    logic [DW-1:0] push_data_o;
    logic          push_grant_i;
    logic [1:0]    owner_o;
    logic          busy_o;

    logic [NR+DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] word [NR] = '{10'h0A1, 10'h132, 10'h155, 10'h3D4};

`ifdef PUSH_ARB_BURST_EN
    localparam int N_RR = 9;
    int rr_owner [N_RR] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
`else
    localparam int N_RR = 6;
    int rr_owner [N_RR] = '{0, 1, 2, 3, 0, 1};
`endif

    push_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR),
        .BURST_LEN (BL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_grant_o (req_grant_o),
        .push_valid_o(push_valid_o),
        .push_data_o (push_data_o),
        .push_grant_i(push_grant_i),
        .owner_o     (owner_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic exp_push(input logic [NR-1:0] g, input logic [DW-1:0] d);
        exp_q.push_back({g, d});
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        req_valid_i  = '0;
        push_grant_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Monitor: every grant must match the oldest expected transfer.
    always @(negedge clk) begin
        logic [NR+DW-1:0] e;
        if (req_grant_o != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", req_grant_o, '0);
            end else begin
                e = exp_q.pop_front();
                check("mon_grant", req_grant_o, e[DW +: NR]);
                check("mon_data", push_data_o, e[DW-1:0]);
            end
        end
    end

    initial begin
        logic [NR-1:0] g;
        req_data_i   = {word[3], word[2], word[1], word[0]};
        reset        = 1'b1;
        req_valid_i  = '1;
        push_grant_i = 1'b1;

        // Reset held with everything requesting.
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            check("rst_grant", req_grant_o, '0);
            check("rst_push_valid", push_valid_o, 1'b0);
            check("rst_busy", busy_o, 1'b0);
            check("rst_owner", owner_o, 2'd0);
        end

        // Single requester 2.
        do_reset();
        req_valid_i  = 4'b0100;
        push_grant_i = 1'b1;
        exp_push(4'b0100, 10'h155);
        tick();
        sample();
        check("single_push_valid", push_valid_o, 1'b1);
        check("single_owner", owner_o, 2'd2);
        check("single_data", push_data_o, 10'h155);
        check("single_grant", req_grant_o, 4'b0100);
        check("single_busy_locked", busy_o, 1'b1);
        tick();
        req_valid_i = '0;
        sample();
        check("single_busy_after", busy_o, 1'b0);
        check("single_valid_after", push_valid_o, 1'b0);
        check("single_owner_idle", owner_o, 2'd2);
        check("single_data_idle", push_data_o, 10'h0);
        check("single_q_empty", exp_q.size(), 0);

        // All four requesting continuously.
        do_reset();
        req_valid_i  = 4'b1111;
        push_grant_i = 1'b1;
        for (int n = 0; n < N_RR; n++) begin
            g = 4'b0001 << rr_owner[n];
            exp_push(g, word[rr_owner[n]]);
        end
        repeat (2 * N_RR) tick();
        req_valid_i = '0;
        sample();
        check("rr_q_empty", exp_q.size(), 0);

        // Only requester 3.
        do_reset();
        req_valid_i  = 4'b1000;
        push_grant_i = 1'b1;
        for (int n = 0; n < 3; n++) exp_push(4'b1000, 10'h3D4);
        repeat (6) tick();
        req_valid_i = '0;
        sample();
        check("req3_q_empty", exp_q.size(), 0);

        // Downstream stall on owner 1.
        do_reset();
        req_valid_i  = 4'b0010;
        push_grant_i = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            sample();
            check("stall_push_valid", push_valid_o, 1'b1);
            check("stall_owner", owner_o, 2'd1);
            check("stall_data", push_data_o, 10'h132);
            check("stall_grant", req_grant_o, '0);
            tick();
        end
        push_grant_i = 1'b1;
        exp_push(4'b0010, 10'h132);
        sample();
        check("stall_release_grant", req_grant_o, 4'b0010);
        tick();
        req_valid_i = '0;
        sample();
        check("stall_grant_once", req_grant_o, '0);
        check("stall_idle", busy_o, 1'b0);
        check("stall_q_empty", exp_q.size(), 0);

        // Owner 0 drops its request while locked.
        do_reset();
        req_valid_i  = 4'b0001;
        push_grant_i = 1'b0;
        tick();
        req_valid_i  = 4'b0000;
        push_grant_i = 1'b1;
        sample();
        check("drop_grant", req_grant_o, '0);
        check("drop_busy_locked", busy_o, 1'b1);
        tick();
        req_valid_i = 4'b1111;
        exp_push(4'b0001, 10'h0A1);
        sample();
        check("drop_busy_idle", busy_o, 1'b0);
        check("drop_push_valid_idle", push_valid_o, 1'b0);
        tick();
        sample();
        check("drop_ptr_kept_owner", owner_o, 2'd0);
        tick();
        req_valid_i = '0;
        sample();
        check("drop_q_empty", exp_q.size(), 0);

        // Reset asserted while locked on owner 2.
        do_reset();
        req_valid_i  = 4'b0100;
        push_grant_i = 1'b0;
        tick();
        sample();
        check("mid_rst_locked", busy_o, 1'b1);
        reset        = 1'b1;
        push_grant_i = 1'b1;
        #1;
        check("mid_rst_grant", req_grant_o, '0);
        check("mid_rst_push_valid", push_valid_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_data", push_data_o, 10'h0);
        tick();
        reset       = 1'b0;
        req_valid_i = '0;
        sample();
        check("post_rst_busy", busy_o, 1'b0);
        check("post_rst_owner", owner_o, 2'd0);
        check("final_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/push_arbiter.md
PUSH_ARBITER -- requirements
Module: push_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 10, width of each requester's data word.
REQ-002 Parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-003 Parameter BURST_LEN, default 4, maximum consecutive transfers kept by one requester (1..16).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid_i  input  NUM_REQ  bit k: requester k holds a word.
REQ-007 req_data_i  input  NUM_REQ*DATA_WIDTH  requester k's word in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_grant_o  output  NUM_REQ  one-hot; bit k high means requester k's word is accepted this cycle.
REQ-009 push_valid_o  output  1  word offered to the downstream FIFO push port.
REQ-010 push_data_o  output  DATA_WIDTH  word offered downstream.
REQ-011 push_grant_i  input  1  downstream accepts push_data_o this cycle.
REQ-012 owner_o  output  $clog2(NUM_REQ)  index of the current owner.
REQ-013 busy_o  output  1  high while in state LOCKED.

Function
REQ-014 Two-state FSM: IDLE and LOCKED; registers: state, owner, priority pointer ptr, burst counter burst_cnt.
REQ-015 IDLE with any req_valid_i bit high: select the first valid index scanning ptr, ptr+1, ... modulo NUM_REQ; load owner; go to LOCKED on the next edge.
REQ-016 IDLE with no valid request: stay in IDLE; all registers hold.
REQ-017 push_valid_o = 1 and busy_o = 1 exactly while in LOCKED; push_data_o = req_data_i slice of owner (combinational mux); push_data_o = 0 in IDLE.
REQ-018 req_grant_o[owner] = push_grant_i AND LOCKED AND req_valid_i[owner]; all other bits 0; combinational, same-cycle.
REQ-019 Transfer = LOCKED AND push_grant_i AND req_valid_i[owner]; after a transfer, next state is IDLE (one bubble cycle per transfer; maximum throughput 1 word per 2 cycles).
REQ-020 LOCKED with push_grant_i low: hold state, owner and push_data_o stable.
REQ-021 LOCKED with req_valid_i[owner] low (protocol violation): no grant; return to IDLE next edge; ptr and burst_cnt unchanged.
REQ-022 Requests arriving in LOCKED do not preempt the owner; they are considered at the next IDLE cycle.
REQ-023 Selection of an index different from ptr in IDLE clears burst_cnt to 0.
REQ-024 owner_o reflects the owner register in both states.

Reset
REQ-025 While reset is high at a rising edge: state = IDLE, owner = 0, ptr = 0, burst_cnt = 0.
REQ-026 While reset is high, req_grant_o, push_valid_o, push_data_o and busy_o are forced to 0 combinationally; a transfer in flight is abandoned, with no grant issued.
REQ-027 First arbitration is possible in the first cycle after reset deasserts.

Configuration
REQ-028 Macro PUSH_ARB_BURST_EN selects the pointer update on transfer.
REQ-029 Defined: if burst_cnt+1 < BURST_LEN, ptr = owner and burst_cnt increments; otherwise ptr = (owner+1) mod NUM_REQ and burst_cnt = 0.
REQ-030 Not defined: ptr = (owner+1) mod NUM_REQ after every transfer; burst_cnt is held at 0 and BURST_LEN is ignored.

Verification
REQ-031 Reset held 3 cycles with all req_valid_i = 1 and push_grant_i = 1 -> req_grant_o = 0, push_valid_o = 0, busy_o = 0, owner_o = 0 throughout.
REQ-032 Only req 2 valid with data 0x155 from cycle 1, push_grant_i = 1 -> cycle 2: push_valid_o = 1, owner_o = 2, push_data_o = 0x155, req_grant_o = 4'b0100; cycle 3: busy_o = 0.
REQ-033 Macro undefined; all four valid continuously; push_grant_i = 1 -> granted owners 0,1,2,3,0,1 on alternate cycles.
REQ-034 Macro defined, BURST_LEN = 4; all four valid continuously -> owners 0,0,0,0,1,1,1,1,2; only req 3 valid -> owner 3 for every transfer.
REQ-035 LOCKED on owner 1 with push_grant_i low for 5 cycles -> push_valid_o = 1, owner_o = 1 and push_data_o stable; grant raised in cycle 6 -> req_grant_o = 4'b0010 in that cycle only.
REQ-036 LOCKED on owner 0 and req_valid_i[0] dropped -> no grant; IDLE next cycle; ptr unchanged; reset asserted mid-LOCKED -> outputs 0 in that same cycle and IDLE afterwards.
